// File: rtl/alu_cmd_issuer_if.sv
// Request, response and ALU-side signals of the ALU command issuer.
// master = issuer side, slave = requester/consumer/ALU side.
interface alu_cmd_issuer_if #(
    parameter int NUM_SIZE = 32,
    parameter int CMD_W    = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [CMD_W-1:0]           req_cmd;
    logic signed [NUM_SIZE-1:0] req_a;
    logic signed [NUM_SIZE-1:0] req_b;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic signed [NUM_SIZE-1:0] rsp_data;
    logic                       rsp_err;

    logic                       alu_enable;
    logic [CMD_W-1:0]           alu_cmd;
    logic signed [NUM_SIZE-1:0] alu_in1;
    logic signed [NUM_SIZE-1:0] alu_in2;
    logic                       alu_valid;
    logic signed [NUM_SIZE-1:0] alu_out;

    modport master (
        input  req_valid, req_cmd, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output alu_enable, alu_cmd, alu_in1, alu_in2,
        input  alu_valid, alu_out
    );

    modport slave (
        output req_valid, req_cmd, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  alu_enable, alu_cmd, alu_in1, alu_in2,
        output alu_valid, alu_out
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU requests, issues them one at a time and returns results in order.
// Define ISSUER_STATS_EN to add the stat_ops/stat_tmo response counters.
module alu_cmd_issuer #(
    parameter int NUM_SIZE   = 32,
    parameter int CMD_W      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    alu_cmd_issuer_if.master bus,
    output logic             busy
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_tmo
`endif
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [CMD_W-1:0] CMD_NOOP  = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [CMD_W-1:0]           fifo_cmd [FIFO_DEPTH];
    logic signed [NUM_SIZE-1:0] fifo_a   [FIFO_DEPTH];
    logic signed [NUM_SIZE-1:0] fifo_b   [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [PTR_W:0]             count;
    logic                       full, empty, push, pop;

    logic [CMD_W-1:0]           head_cmd;
    logic                       head_noop;

    logic [CMD_W-1:0]           op_cmd;
    logic signed [NUM_SIZE-1:0] op_a, op_b;
    logic signed [NUM_SIZE-1:0] rsp_data_reg;
    logic                       rsp_err_reg;
    logic [7:0]                 tmo_cnt;
    logic                       tmo_hit;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign push      = bus.req_valid && !full;
    assign head_cmd  = fifo_cmd[rd_ptr];
    assign head_noop = (head_cmd == CMD_NOOP);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    // Request FIFO: storage is not reset, only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= bus.req_cmd;
            fifo_a[wr_ptr]   <= bus.req_a;
            fifo_b[wr_ptr]   <= bus.req_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = head_noop ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.alu_valid || tmo_hit) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand/result capture; alu_valid takes priority over an expiring timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_cmd       <= '0;
            op_a         <= '0;
            op_b         <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (head_noop) begin
                            rsp_data_reg <= '0;
                            rsp_err_reg  <= 1'b0;
                        end else begin
                            op_cmd <= head_cmd;
                            op_a   <= fifo_a[rd_ptr];
                            op_b   <= fifo_b[rd_ptr];
                        end
                    end
                end
                S_ISSUE: tmo_cnt <= '0;
                S_WAIT: begin
                    if (bus.alu_valid) begin
                        rsp_data_reg <= bus.alu_out;
                        rsp_err_reg  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data_reg <= bus.alu_out;
                        rsp_err_reg  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = !full;
    assign bus.alu_enable = (state == S_ISSUE) || (state == S_WAIT);
    assign bus.alu_cmd    = op_cmd;
    assign bus.alu_in1    = op_a;
    assign bus.alu_in2    = op_b;
    assign bus.rsp_valid  = (state == S_RESP);
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_err    = rsp_err_reg;
    assign busy           = !empty || (state != S_IDLE);

`ifdef ISSUER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ops <= '0;
            stat_tmo <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            stat_ops <= sat_inc16(stat_ops);
            if (bus.rsp_err) stat_tmo <= sat_inc16(stat_tmo);
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a simple registered ALU model
// (valid after alu_lat enabled edges for ADD only; out = in1+in2 while enabled).
module tb_alu_cmd_issuer;
    localparam int NUM_SIZE   = 32;
    localparam int CMD_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    logic clk = 1'b0;
    logic reset;
    logic busy;
`ifdef ISSUER_STATS_EN
    logic [15:0] stat_ops, stat_tmo;
`endif

    alu_cmd_issuer_if #(.NUM_SIZE(NUM_SIZE), .CMD_W(CMD_W)) bus ();

    alu_cmd_issuer #(
        .NUM_SIZE(NUM_SIZE), .CMD_W(CMD_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master),
        .busy(busy)
`ifdef ISSUER_STATS_EN
        ,
        .stat_ops(stat_ops),
        .stat_tmo(stat_tmo)
`endif
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int alu_lat = 1;
    bit alu_never = 1'b0;
    int en_cnt = 0;

    always @(posedge clk) begin
        if (!bus.alu_enable) begin
            bus.alu_valid <= 1'b0;
            bus.alu_out   <= '0;
            en_cnt        <= 0;
        end else begin
            en_cnt      <= en_cnt + 1;
            bus.alu_out <= bus.alu_in1 + bus.alu_in2;
            if (!alu_never && bus.alu_cmd == 4'd1 && en_cnt + 1 >= alu_lat)
                bus.alu_valid <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [3:0] cmd, input int a, input int b);
        int n;
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_rdy", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input int exp_data, input logic exp_err);
        int n;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // ISSUE observed, then exactly TIMEOUT WAIT cycles, then RESP.
    task automatic run_timed(input string tag, input logic [3:0] cmd, input int a, input int b,
                             input int exp_data, input logic exp_err);
        int n, quiet;
        push_one(cmd, a, b);
        n = 0;
        while (!bus.alu_enable && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_issue"}, 32'(bus.alu_enable), 32'd1);
        quiet = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            tick();
            if (!bus.rsp_valid && bus.alu_enable) quiet++;
        end
        chk({tag, "_wait_cycles"}, quiet, TIMEOUT);
        tick();
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_en_low"}, 32'(bus.alu_enable), 32'd0);
        get_rsp(tag, exp_data, exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, saw;
        logic acc, hs, e;
        logic [31:0] d;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
        chk("rst_alu_cmd", 32'(bus.alu_cmd), 32'd0);
        chk("rst_alu_in1", bus.alu_in1, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // ADD 5 + -3, ALU valid one cycle after ISSUE
        alu_lat = 1;
        push_one(4'd1, 5, -3);
        chk("add_busy", 32'(busy), 32'd1);
        chk("add_idle_en", 32'(bus.alu_enable), 32'd0);
        tick();
        chk("add_issue_en", 32'(bus.alu_enable), 32'd1);
        chk("add_issue_cmd", 32'(bus.alu_cmd), 32'd1);
        chk("add_issue_in1", bus.alu_in1, 32'd5);
        chk("add_issue_in2", bus.alu_in2, -32'sd3);
        tick();
        chk("add_wait_en", 32'(bus.alu_enable), 32'd1);
        tick();
        chk("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_rsp_data", bus.rsp_data, 32'd2);
        chk("add_rsp_en_low", 32'(bus.alu_enable), 32'd0);
        tick();
        chk("add_hold_valid", 32'(bus.rsp_valid), 32'd1);
        chk("add_hold_data", bus.rsp_data, 32'd2);
        get_rsp("add", 2, 1'b0);
        chk("add_done_busy", 32'(busy), 32'd0);

        // Fill the FIFO while the head op sits in RESP, then drain in order
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            bus.req_valid = 1'b1;
            bus.req_cmd   = 4'd1;
            bus.req_a     = i * 11 - 20;
            bus.req_b     = i * 5;
            chk("fill_rdy", 32'(bus.req_ready), 32'd1);
            tick();
        end
        chk("full_rdy", 32'(bus.req_ready), 32'd0);
        bus.req_a = (FIFO_DEPTH + 1) * 11 - 20;
        bus.req_b = (FIFO_DEPTH + 1) * 5;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_rdy", 32'(bus.req_ready), 32'd0);
        end
        chk("full_head_data", bus.rsp_data, -32'sd20);
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int n = 0; n < 300 && got < FIFO_DEPTH + 2; n++) begin
            acc = bus.req_valid && bus.req_ready;
            hs  = bus.rsp_valid && bus.rsp_ready;
            d   = bus.rsp_data;
            e   = bus.rsp_err;
            tick();
            if (acc) bus.req_valid = 1'b0;
            if (hs) begin
                chk("order_data", d, got * 16 - 20);
                chk("order_err", 32'(e), 32'd0);
                got++;
            end
        end
        chk("drain_count", got, FIFO_DEPTH + 2);
        bus.rsp_ready = 1'b0;
        tick();
        chk("drain_busy", 32'(busy), 32'd0);

        // ALU never responds: timeout exactly TIMEOUT WAIT cycles after ISSUE
        alu_never = 1'b1;
        run_timed("tmo", 4'd1, 20, 22, 42, 1'b1);
        alu_never = 1'b0;

        // Valid on the final WAIT cycle wins over the timeout
        alu_lat = TIMEOUT;
        run_timed("last", 4'd1, -100, 33, -67, 1'b0);
        // One cycle later is too late
        alu_lat = TIMEOUT + 1;
        run_timed("late", 4'd1, 1000, 24, 1024, 1'b1);
        alu_lat = 1;

        // Unknown opcode is issued unchanged and times out
        push_one(4'hA, 3, 4);
        tick();
        chk("unk_cmd", 32'(bus.alu_cmd), 32'hA);
        get_rsp("unk", 7, 1'b1);

        // NOOP never touches the ALU
        push_one(4'd0, 9, 9);
        saw = 0;
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) begin
            if (bus.alu_enable) saw = 1;
            tick();
        end
        chk("noop_en", saw, 0);
        get_rsp("noop", 0, 1'b0);

        // Reset during WAIT with two requests still queued
        alu_never     = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 1'b1;
            bus.req_cmd   = 4'd1;
            bus.req_a     = i;
            bus.req_b     = i;
            tick();
        end
        bus.req_valid = 1'b0;
        tick();
        chk("prerst_wait_en", 32'(bus.alu_enable), 32'd1);
        chk("prerst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_en", 32'(bus.alu_enable), 32'd0);
        saw = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (bus.rsp_valid || busy) saw = 1;
        end
        chk("midrst_quiet", saw, 0);
        bus.rsp_ready = 1'b0;
        alu_never     = 1'b0;
        push_one(4'd1, 7, 8);
        get_rsp("postrst", 15, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
